// File: rtl/mem_port_arbiter.sv
// MEM-stage data-memory arbiter: pipeline load/store vs debug/loader port,
// with stall generation, access timeout and debug anti-starvation.
module mem_port_arbiter #(
  parameter int TIMEOUT    = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_rd,
  input  logic        pipe_wr,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  output logic [31:0] pipe_rdata,
  output logic        pipe_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    PIPE,
    DBG
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] starve_cnt;
  logic          pipe_done_q;
  logic          ill_q;

  logic pipe_any;
  logic pipe_pend;
  logic dbg_elig;
  logic starve_hit;
  logic tmo;
  logic pipe_win;
  logic dbg_win;
  logic fin;

  assign pipe_any   = pipe_rd | pipe_wr;
  assign pipe_pend  = pipe_any & ~pipe_done_q;
  assign dbg_elig   = dbg_req & ~dbg_done;
  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
  assign tmo        = (tcnt == TW'(TIMEOUT - 1));

  // Stall is forced low while reset is held so all outputs read zero.
  assign pipe_stall = reset & (pipe_pend | (state == PIPE));

  // Debug only overtakes a raw pipe request once starvation is reached.
  always_comb begin
    state_n  = state;
    pipe_win = 1'b0;
    dbg_win  = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        dbg_win  = dbg_elig & (~pipe_any | starve_hit);
        pipe_win = pipe_pend & ~dbg_win;
        if (dbg_win)
          state_n = DBG;
        else if (pipe_win)
          state_n = PIPE;
      end
      PIPE, DBG: begin
        fin = mem_ack | tmo;
        if (fin)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt        <= '0;
      starve_cnt  <= '0;
      pipe_done_q <= 1'b0;
      ill_q       <= 1'b0;
      pipe_rdata  <= '0;
      pipe_err    <= 1'b0;
      dbg_done    <= 1'b0;
      dbg_rdata   <= '0;
      dbg_err     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      pipe_done_q <= 1'b0;
      pipe_err    <= 1'b0;
      dbg_done    <= 1'b0;
      dbg_err     <= 1'b0;
      if (pipe_win || dbg_win) begin
        mem_req   <= 1'b1;
        tcnt      <= '0;
        mem_we    <= pipe_win ? pipe_wr : dbg_we;
        mem_addr  <= pipe_win ? pipe_addr : dbg_addr;
        mem_wdata <= pipe_win ? pipe_wdata : dbg_wdata;
        ill_q     <= pipe_win & pipe_rd & pipe_wr;
        if (dbg_win)
          starve_cnt <= '0;
        else if (dbg_req && !starve_hit)
          starve_cnt <= starve_cnt + SW'(1);
      end else if (fin) begin
        mem_req <= 1'b0;
        if (state == PIPE) begin
          pipe_done_q <= 1'b1;
          pipe_err    <= ~mem_ack | ill_q;
          if (!mem_ack)
            pipe_rdata <= '0;
          else if (!mem_we)
            pipe_rdata <= mem_rdata;
        end else begin
          dbg_done  <= 1'b1;
          dbg_err   <= ~mem_ack;
          dbg_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
        end
      end else if (state != IDLE) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of pipe accesses plus hand sequences,
// grant/completion scoreboards fed at stimulus time, popped on DUT output.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_rd = 1'b0;
  logic        pipe_wr = 1'b0;
  logic [31:0] pipe_addr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        pipe_stall;
  logic [31:0] pipe_rdata;
  logic        pipe_err;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_done;
  logic [31:0] dbg_rdata;
  logic        dbg_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.TIMEOUT(64), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
    .pipe_err(pipe_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .dbg_err(dbg_err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } cpl_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          stall;
    int          req;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  grant_t gq[$];
  cpl_t   pq[$];
  cpl_t   dq[$];
  vec_t   vt[5];

  int   n_tests = 0;
  int   n_fail = 0;
  int   ack_lat = 0;
  int   lat_cnt = 0;
  logic resp_on = 1'b1;
  logic late_ack = 1'b0;
  logic chk_starve = 1'b0;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'h100)
      return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic exp_grant(input logic we, input logic [31:0] a,
                           input logic [31:0] d);
    gq.push_back('{we, a, d});
  endtask

  // Memory responder: ack ack_lat cycles after mem_req first seen high.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (late_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        late_ack = 1'b0;
      end else if (!mem_req) begin
        lat_cnt = 0;
      end else if (resp_on) begin
        if (lat_cnt >= ack_lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_we ? 32'hBAD0BAD0 : rd_of(mem_addr);
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end
    end
  end

  // Scoreboard monitor: grants on mem_req rise, completions on stall fall.
  initial begin
    logic   sp;
    logic   rp;
    grant_t g;
    cpl_t   c;
    sp = 1'b0;
    rp = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sp = 1'b0;
        rp = 1'b0;
      end else begin
        if (mem_req && !rp) begin
          if (gq.size() == 0) begin
            fail("grant_unexpected");
          end else begin
            g = gq.pop_front();
            check("grant_we", 32'(mem_we), 32'(g.we));
            check("grant_addr", mem_addr, g.addr);
            check("grant_wdata", mem_wdata, g.wdata);
          end
        end
        if (sp && !pipe_stall) begin
          if (pq.size() == 0) begin
            fail("pipe_cpl_unexpected");
          end else begin
            c = pq.pop_front();
            check("pipe_rdata", pipe_rdata, c.rdata);
            check("pipe_err", 32'(pipe_err), 32'(c.err));
          end
        end
        if (dbg_done) begin
          if (dq.size() == 0) begin
            fail("dbg_cpl_unexpected");
          end else begin
            c = dq.pop_front();
            check("dbg_rdata", dbg_rdata, c.rdata);
            check("dbg_err", 32'(dbg_err), 32'(c.err));
          end
          if (chk_starve)
            check("starve_cnt_clear", 32'(dut.starve_cnt), 32'd0);
        end
        sp = pipe_stall;
        rp = mem_req;
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the edge the pipe advances.
  task automatic pipe_access(input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             input int exp_stall, input int exp_req,
                             input logic [31:0] exp_rd, input logic exp_err);
    int ns;
    int nr;
    ns = 0;
    nr = 0;
    pq.push_back('{exp_rd, exp_err});
    pipe_rd = rd;
    pipe_wr = wr;
    pipe_addr = a;
    pipe_wdata = d;
    forever begin
      @(negedge clk);
      if (!pipe_stall)
        break;
      ns++;
      if (mem_req)
        nr++;
      if (ns > 300) begin
        fail("pipe_stall_timeout");
        break;
      end
    end
    if (exp_stall >= 0)
      check("stall_cycles", ns, exp_stall);
    if (exp_req >= 0)
      check("req_cycles", nr, exp_req);
    @(posedge clk);
    #1;
    pipe_rd = 1'b0;
    pipe_wr = 1'b0;
  endtask

  task automatic dbg_access(input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd,
                            input logic exp_err);
    int n;
    n = 0;
    dq.push_back('{exp_rd, exp_err});
    dbg_we = we;
    dbg_addr = a;
    dbg_wdata = d;
    dbg_req = 1'b1;
    forever begin
      @(negedge clk);
      if (dbg_done)
        break;
      n++;
      if (n > 400) begin
        fail("dbg_done_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    vt[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        3, 5, 4, 32'hDEADBEEF, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 0, 2, 1, 32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h3F0, 32'h0,        1, 3, 2, 32'h03F0FC0F, 1'b0};
    vt[3] = '{1'b1, 1'b1, 32'h40,  32'h12345678, 2, 4, 3, 32'h03F0FC0F, 1'b1};
    vt[4] = '{1'b1, 1'b0, 32'h8,   32'h0,        0, 2, 1, 32'h0008FFF7, 1'b0};

    #12;
    check("rst_stall", 32'(pipe_stall), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pipe_rdata", pipe_rdata, 0);
    check("rst_dbg_done", 32'(dbg_done), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      ack_lat = vt[i].lat;
      exp_grant(vt[i].wr, vt[i].addr, vt[i].wdata);
      pipe_access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata,
                  vt[i].stall, vt[i].req, vt[i].rdata, vt[i].err);
    end

    resp_on = 1'b0;
    exp_grant(1'b0, 32'h500, 32'h0);
    pipe_access(1'b1, 1'b0, 32'h500, 32'h0, 65, 64, 32'h0, 1'b1);
    resp_on = 1'b1;

    ack_lat = 1;
    exp_grant(1'b1, 32'h600, 32'hA1A2A3A4);
    exp_grant(1'b0, 32'h700, 32'h0);
    fork
      pipe_access(1'b0, 1'b1, 32'h600, 32'hA1A2A3A4, 3, 2, 32'h0, 1'b0);
      dbg_access(1'b0, 32'h700, 32'h0, rd_of(32'h700), 1'b0);
    join
    exp_grant(1'b1, 32'h704, 32'h55AA55AA);
    dbg_access(1'b1, 32'h704, 32'h55AA55AA, 32'h0, 1'b0);

    ack_lat = 2;
    chk_starve = 1'b1;
    exp_grant(1'b0, 32'h10, 32'h0);
    exp_grant(1'b0, 32'h14, 32'h0);
    exp_grant(1'b0, 32'h18, 32'h0);
    exp_grant(1'b0, 32'h1C, 32'h0);
    exp_grant(1'b0, 32'h800, 32'h0);
    exp_grant(1'b0, 32'h20, 32'h0);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          pipe_access(1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'h0, 4, 3,
                      rd_of(32'h10 + 32'(4 * i)), 1'b0);
        end
        pipe_access(1'b1, 1'b0, 32'h20, 32'h0, -1, -1,
                    rd_of(32'h20), 1'b0);
      end
      dbg_access(1'b0, 32'h800, 32'h0, rd_of(32'h800), 1'b0);
    join
    chk_starve = 1'b0;

    ack_lat = 10;
    exp_grant(1'b0, 32'h900, 32'h0);
    pipe_rd = 1'b1;
    pipe_addr = 32'h900;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_mem_req", 32'(mem_req), 0);
    check("async_stall", 32'(pipe_stall), 0);
    check("async_mem_addr", mem_addr, 0);
    check("async_pipe_rdata", pipe_rdata, 0);
    check("async_dbg_rdata", dbg_rdata, 0);
    pipe_rd = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    late_ack = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pipe_err || dbg_done || mem_req || pipe_stall)
        bad = 1'b1;
    end
    check("late_ack_ignored", 32'(bad), 0);

    @(posedge clk);
    #1;
    ack_lat = 0;
    exp_grant(1'b0, 32'h104, 32'h0);
    pipe_access(1'b1, 1'b0, 32'h104, 32'h0, 2, 1, rd_of(32'h104), 1'b0);

    repeat (3) @(posedge clk);
    check("grant_q_empty", gq.size(), 0);
    check("pipe_q_empty", pq.size(), 0);
    check("dbg_q_empty", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the data-memory side of the MEM stage.
- Takes the load/store request held in the EX/MEM pipeline register and a secondary debug/loader port, and arbitrates both onto a single multi-cycle data-memory req/ack interface.
- Drives pipe_stall to freeze the EX/MEM register and all earlier stages until the access completes.
- Provides a timeout and anti-starvation for the debug port.

Parameters:
TIMEOUT, 64, cycles waiting for mem_ack before the access is aborted (min 2)
STARVE_MAX, 4, consecutive pipeline grants allowed while dbg_req is pending before debug is forced through

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
pipe_rd  input  1  MEM-stage load request (data_read from EX/MEM)
pipe_wr  input  1  MEM-stage store request (data_write from EX/MEM)
pipe_addr  input  32  MEM-stage byte address
pipe_wdata  input  32  MEM-stage store data
pipe_stall  output  1  freeze EX/MEM and upstream pipeline registers
pipe_rdata  output  32  load data; valid in the cycle pipe_stall first falls
pipe_err  output  1  one-cycle pulse: pipeline access timed out or was illegal
dbg_req  input  1  debug access request, level, held until dbg_done
dbg_we  input  1  debug write enable
dbg_addr  input  32  debug address
dbg_wdata  input  32  debug write data
dbg_done  output  1  one-cycle completion pulse
dbg_rdata  output  32  debug read data; valid with dbg_done
dbg_err  output  1  with dbg_done: access timed out
mem_req  output  1  memory request, registered
mem_we  output  1  memory write enable
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_ack  input  1  memory completion, single-cycle pulse
mem_rdata  input  32  memory read data; valid with mem_ack

Behaviour:
- Reset values: all outputs 0. State IDLE, timeout counter 0, starvation counter 0, done flags 0. mem_req drops asynchronously on reset. Any mem_ack arriving in IDLE is ignored.
- States and transitions:
  - IDLE -> PIPE when a pipe request is pending and it wins arbitration.
  - IDLE -> DBG when dbg_req wins arbitration.
  - PIPE/DBG -> IDLE on mem_ack or on timeout.
- Pipe request pending = (pipe_rd|pipe_wr) & ~pipe_done_q. Debug eligible = dbg_req & ~dbg_done.
- Arbitration (IDLE only):
  - Pipeline wins by default.
  - Debug wins if no pipe request is pending, or if the starvation counter == STARVE_MAX.
  - The starvation counter increments on each pipe grant made while dbg_req is high, and clears on a debug grant.
- Grant edge:
  - mem_req=1; mem_we/mem_addr/mem_wdata are latched from the winner.
  - The latched values stay stable until mem_req falls.
  - mem_req falls in the cycle after mem_ack (the registered edge at the ack).
- pipe_stall = pipe request pending, or state==PIPE. It is combinational from pipe_rd/pipe_wr, so it asserts in the same cycle the request appears.
- Pipe completion (mem_ack in PIPE at cycle k):
  - Cycle k+1: state IDLE, pipe_done_q=1, pipe_stall=0, pipe_rdata=captured mem_rdata.
  - The pipeline advances on the k+1 edge; pipe_done_q clears on that edge.
  - pipe_rdata holds its value until the next pipe completion.
- Best-case latency: request at cycle 0, grant edge end of cycle 0, ack in cycle 1, stall low in cycle 2.
- Debug completion (mem_ack in DBG): dbg_done=1 for one cycle with dbg_rdata valid. The requester drops dbg_req at that edge; no re-grant to debug occurs while dbg_done=1.
- Timeout:
  - The counter counts busy cycles without mem_ack and reaches TIMEOUT-1 -> abort.
  - On abort: mem_req drops, the state returns to IDLE, and the completion is taken exactly as for an ack, with rdata=0 and pipe_err or dbg_err=1.
  - The counter clears on every grant.
- Illegal pipe request (pipe_rd & pipe_wr): the access is performed as a write, and pipe_err pulses at completion.
- Stores (write accesses): rdata outputs are unchanged.
- Debug writes: dbg_rdata=0.
- An access already granted is never pre-empted; a pipe request arriving while in DBG waits with pipe_stall high.
- Asynchronous reset mid-access: immediate abort, no completion pulse, no error.

Test Plan:
- Pipe load, addr 0x100, mem_ack 3 cycles after mem_req rises, mem_rdata 0xDEADBEEF -> pipe_stall high 5 cycles (request cycle through ack cycle), then low with pipe_rdata=0xDEADBEEF; mem_addr=0x100, mem_we=0.
- dbg_req and pipe_wr raised in the same cycle -> pipe granted first. The debug grant comes in the cycle after the pipe completion, provided no new pipe request is present.
- Continuous back-to-back pipe loads with dbg_req held high, STARVE_MAX=4 -> after 4 pipe grants debug is granted, then the starvation counter reads 0.
- mem_ack never returns, TIMEOUT=64 -> mem_req drops after 64 busy cycles; the next cycle shows pipe_err=1, pipe_rdata=0, pipe_stall=0.
- Reset asserted 2 cycles into a PIPE access, then a late mem_ack after reset release -> all outputs 0 immediately on reset; the late ack is ignored, and no pipe_err or dbg_done occurs.
- pipe_rd=pipe_wr=1, wdata 0x12345678 -> mem_we=1 with mem_wdata=0x12345678; pipe_err pulses at completion.
